// File: rtl/debounce_pkg.sv
// debounce_pkg: shared constants, state type and counter-width helper for the
// two-channel input conditioner (filtro_debounce / debounce_canal).
//   ESTAVEL_PADRAO : default number of consecutive disagreeing cycles to switch
//   N_CANAIS       : default channel count
//   estado_t       : per-channel stable level (the debounced output itself)
//   largura_cnt()  : width of the debounce counter for a given ESTAVEL
package debounce_pkg;

  localparam int ESTAVEL_PADRAO = 4;
  localparam int N_CANAIS       = 2;

  // The per-channel state machine is held in the output flop: the two stable
  // levels are the only states, the counter just measures how long s2 has
  // disagreed with the current one.
  typedef enum logic {
    ESTAVEL_0 = 1'b0,
    ESTAVEL_1 = 1'b1
  } estado_t;

  // Counter must hold 0..ESTAVEL-1. Clamp to 1 bit so an out-of-range
  // parameter still elaborates to a legal width.
  function automatic int largura_cnt(input int estavel);
    return (estavel < 2) ? 1 : $clog2(estavel);
  endfunction

endpackage

// File: rtl/debounce_canal.sv
// debounce_canal: one channel of the input conditioner.
//   clk   : rising-edge clock
//   rst   : synchronous, active-high reset (clears s1, s2, cnt, saida)
//   bruto : raw asynchronous input
//   saida : debounced, registered level
// Two-flop synchroniser followed by a disagreement counter. saida only follows
// s2 after ESTAVEL consecutive cycles of disagreement; one agreeing cycle
// drops the counter back to zero.
module debounce_canal
  import debounce_pkg::*;
#(
  parameter int ESTAVEL = ESTAVEL_PADRAO
) (
  input  logic clk,
  input  logic rst,
  input  logic bruto,
  output logic saida
);

  localparam int            CW      = largura_cnt(ESTAVEL);
  localparam logic [CW-1:0] CNT_MAX = CW'(ESTAVEL - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  estado_t       estado;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      estado <= ESTAVEL_0;
    end else begin
      s1 <= bruto;
      s2 <= s1;
      if (s2 == logic'(estado)) begin
        cnt <= '0;
      end else if (cnt < CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end else begin
        // ESTAVEL-th consecutive disagreeing sample: switch level, restart.
        estado <= estado_t'(s2);
        cnt    <= '0;
      end
    end
  end

  assign saida = logic'(estado);

endmodule

// File: rtl/filtro_debounce.sv
// filtro_debounce: N-channel synchroniser + debouncer feeding detector_borda.
//   clk   : rising-edge clock
//   rst   : synchronous, active-high reset
//   bruto : [N-1:0] raw asynchronous inputs
//   saida : [N-1:0] debounced registered levels (to detector_borda.entrada)
// Channels are fully independent; each is one debounce_canal instance.
module filtro_debounce
  import debounce_pkg::*;
#(
  parameter int N       = N_CANAIS,
  parameter int ESTAVEL = ESTAVEL_PADRAO
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] bruto,
  output logic [N-1:0] saida
);

  for (genvar g = 0; g < N; g++) begin : g_canal
    debounce_canal #(
      .ESTAVEL(ESTAVEL)
    ) u_canal (
      .clk  (clk),
      .rst  (rst),
      .bruto(bruto[g]),
      .saida(saida[g])
    );
  end

endmodule

// File: tb/tb_filtro_debounce.sv
// Bench for filtro_debounce (N=2, ESTAVEL=4, 2-unit clock). Directed scenarios
// are checked against edge-count expectations; a randomized run is checked
// against a window-based reference: after a two-edge delay, saida flips when
// the last ESTAVEL delayed samples since reset all disagree with it.
module tb_filtro_debounce;

  localparam int N   = 2;
  localparam int EST = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] bruto;
  logic [N-1:0] saida;

  int checks   = 0;
  int failures = 0;

  filtro_debounce #(.N(N), .ESTAVEL(EST)) dut (
    .clk  (clk),
    .rst  (rst),
    .bruto(bruto),
    .saida(saida)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  // Reference model state
  logic [N-1:0] m_d1, m_d2, m_saida;
  logic [N-1:0] hist[$];

  // One rising edge with the currently driven inputs; model updated, then
  // returns at the following falling edge where outputs are sampled.
  task automatic step();
    logic         r;
    logic [N-1:0] b;
    r = rst;
    b = bruto;
    @(posedge clk);
    if (r) begin
      m_d1    = '0;
      m_d2    = '0;
      m_saida = '0;
      hist.delete();
    end else begin
      hist.push_back(m_d2);
      if (hist.size() > EST) void'(hist.pop_front());
      if (hist.size() == EST) begin
        for (int c = 0; c < N; c++) begin
          bit all_diff;
          all_diff = 1'b1;
          for (int j = 0; j < EST; j++)
            if (hist[j][c] == m_saida[c]) all_diff = 1'b0;
          if (all_diff) m_saida[c] = ~m_saida[c];
        end
      end
      m_d2 = m_d1;
      m_d1 = b;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [N-1:0] b);
    rst   = 1'b1;
    bruto = b;
    step();
    rst   = 1'b0;
  endtask

  task automatic test_reset();
    logic [N-1:0] exp;
    rst   = 1'b1;
    bruto = 2'b11;
    for (int k = 1; k <= 2; k++) begin
      step();
      checks++;
      if (saida !== 2'b00) begin
        failures++;
        $display("FAIL reset_hold edge=%0d saida=%b expected=%b", k, saida, 2'b00);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp = (k >= 6) ? 2'b11 : 2'b00;
      checks++;
      if (saida !== exp) begin
        failures++;
        $display("FAIL reset_release edge=%0d saida=%b expected=%b", k, saida, exp);
      end
    end
  endtask

  task automatic test_clean_rise();
    logic [N-1:0] exp;
    do_reset(2'b00);
    bruto = 2'b01;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp = (k >= 6) ? 2'b01 : 2'b00;
      checks++;
      if (saida !== exp) begin
        failures++;
        $display("FAIL clean_rise edge=%0d saida=%b expected=%b", k, saida, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [N-1:0] exp;
    do_reset(2'b00);
    for (int k = 1; k <= 13; k++) begin
      bruto = (k <= 3) ? 2'b10 : 2'b00;
      step();
      checks++;
      if (saida !== 2'b00) begin
        failures++;
        $display("FAIL glitch_3 edge=%0d saida=%b expected=%b", k, saida, 2'b00);
      end
    end
    for (int k = 1; k <= 14; k++) begin
      bruto = (k <= 4) ? 2'b10 : 2'b00;
      step();
      exp = (k >= 6 && k < 10) ? 2'b10 : 2'b00;
      checks++;
      if (saida !== exp) begin
        failures++;
        $display("FAIL glitch_4 edge=%0d saida=%b expected=%b", k, saida, exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [N-1:0] exp;
    logic [4:0]   seq;
    seq = 5'b10101;  // bit 4 first: 1,0,1,0,1
    do_reset(2'b00);
    for (int k = 1; k <= 16; k++) begin
      bruto = (k <= 5) ? {1'b0, seq[5-k]} : 2'b01;
      step();
      exp = (k >= 10) ? 2'b01 : 2'b00;
      checks++;
      if (saida !== exp) begin
        failures++;
        $display("FAIL bounce edge=%0d saida=%b expected=%b", k, saida, exp);
      end
    end
  endtask

  task automatic test_simul_fall();
    logic [N-1:0] exp;
    do_reset(2'b00);
    bruto = 2'b11;
    for (int k = 1; k <= 8; k++) step();
    checks++;
    if (saida !== 2'b11) begin
      failures++;
      $display("FAIL simul_fall_pre saida=%b expected=%b", saida, 2'b11);
    end
    bruto = 2'b00;
    for (int k = 1; k <= 9; k++) begin
      step();
      exp = (k >= 6) ? 2'b00 : 2'b11;
      checks++;
      if (saida !== exp) begin
        failures++;
        $display("FAIL simul_fall edge=%0d saida=%b expected=%b", k, saida, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] exp;
    do_reset(2'b00);
    bruto = 2'b01;
    for (int k = 1; k <= 4; k++) step();  // counter now at 2
    rst = 1'b1;
    step();
    checks++;
    if (saida !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid_hold saida=%b expected=%b", saida, 2'b00);
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp = (k >= 6) ? 2'b01 : 2'b00;
      checks++;
      if (saida !== exp) begin
        failures++;
        $display("FAIL reset_mid edge=%0d saida=%b expected=%b", k, saida, exp);
      end
    end
  endtask

  task automatic test_random();
    int hold[N];
    int nfail;
    nfail = 0;
    for (int c = 0; c < N; c++) hold[c] = 0;
    do_reset(2'b00);
    for (int it = 0; it < 3000; it++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int c = 0; c < N; c++) begin
        if (hold[c] == 0) begin
          bruto[c] = $urandom_range(0, 1);
          hold[c]  = $urandom_range(1, 7);
        end
        hold[c]--;
      end
      step();
      checks++;
      if (saida !== m_saida) begin
        failures++;
        nfail++;
        if (nfail <= 10)
          $display("FAIL random it=%0d saida=%b expected=%b", it, saida, m_saida);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    bruto   = '0;
    m_d1    = '0;
    m_d2    = '0;
    m_saida = '0;
    test_reset();
    test_clean_rise();
    test_glitch();
    test_bounce();
    test_simul_fall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/filtro_debounce.md
# filtro_debounce

Two-channel input conditioner that sits directly upstream of `detector_borda`. It synchronises raw asynchronous inputs (buttons, switches) into the `clk` domain. It then debounces each channel independently, so that `detector_borda` sees only clean, glitch-free levels on its `entrada` bus. The output `saida` connects straight to `detector_borda.entrada`.

## Interface
- `N`, default 2: number of independent channels.
- `ESTAVEL`, default 4: consecutive cycles a synchronised level must differ from `saida` before `saida` follows it; legal range ≥ 2.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `bruto` input N: raw, asynchronous, possibly bouncing inputs.
- `saida` output N: debounced, registered levels; feeds `detector_borda.entrada`.

## Operation
- Per channel, identical and fully independent; no cross-channel interaction.
- Stage 1, synchroniser: two flops in series, `s1 <= bruto[i]`, `s2 <= s1`. Only `s2` is used downstream.
- Stage 2, debounce counter `cnt`, width `$clog2(ESTAVEL)`:
  - `s2 == saida[i]`: `cnt <= 0`.
  - `s2 != saida[i]` and `cnt < ESTAVEL-1`: `cnt <= cnt + 1`.
  - `s2 != saida[i]` and `cnt == ESTAVEL-1`: `saida[i] <= s2`, `cnt <= 0`.
- Effective two-state machine per channel, `ESTAVEL_0` and `ESTAVEL_1`, held in `saida[i]` itself:
  - A transition requires `ESTAVEL` consecutive cycles of a disagreeing `s2`.
  - Any single agreeing cycle returns the counter to 0. There is no partial credit.
- Rising and falling transitions are treated symmetrically.
- `cnt` never exceeds `ESTAVEL-1`, so no wrap-around is possible.
- Both channels changing on the same edge is legal. Each channel updates on its own schedule, and simultaneous `saida` changes are allowed.

## Timing
- Reset (`rst` high at a rising edge): `s1`, `s2`, `cnt` and `saida` all go to 0.
- `saida` = 0 from the first edge with `rst` high until the debounce conditions are met after release.
- Reset mid-count discards all progress. Counting restarts from 0 on the first edge with `rst` low.
- Latency for a clean level change: count as edge 1 the first rising edge that samples the new `bruto` level. `saida` takes the new value after edge `ESTAVEL+2`, which is 6 edges with the default.
- Rejection threshold:
  - A `bruto` pulse held for fewer than `ESTAVEL` sampling edges never reaches `saida`.
  - A pulse held exactly `ESTAVEL` edges is accepted.
- `saida` is purely registered, with no combinational path from `bruto`. A `saida` change therefore reaches `detector_borda` exactly one cycle before its `detector` pulse.

## Structure
- Shared package `debounce_pkg`:
  - `ESTAVEL_PADRAO = 4`
  - `N_CANAIS = 2`
  - the counter-width function `$clog2(ESTAVEL)`
- Sub-module `debounce_canal`: one channel, containing the synchroniser, counter and output flop.
- `filtro_debounce` instantiates `debounce_canal` `N` times in a generate loop.

## Test plan
All scenarios use `N = 2`, `ESTAVEL = 4`, and a 2-time-unit clock period, matching the existing bench timing.

1. **Reset:** `rst = 1` for 2 edges with `bruto = 2'b11`, then release → `saida = 2'b00` during reset and for the next 5 edges. `saida` becomes `2'b11` after edge 6.
2. **Clean rise:** `bruto = 2'b01`, held 10 edges → `saida[0]` rises after edge 6. `saida[1]` stays 0 throughout.
3. **Glitch rejection:** `bruto[1] = 1` for 3 edges, then 0 → `saida = 2'b00` throughout. Repeat with 4 edges → `saida[1]` rises after edge 6, then falls 6 edges after `bruto[1]` returns to 0.
4. **Bounce:** `bruto[0]` sequence 1,0,1,0,1 on consecutive edges, then stable 1 → `saida[0]` rises exactly 6 edges after the final 0→1 sample, with no intermediate pulse.
5. **Simultaneous fall:** from `saida = 2'b11`, `bruto = 2'b00` → both bits fall on the same edge, edge 6.
6. **Reset mid-count:** `rst = 1` for one edge when `cnt = 2` on a rising channel → `saida` stays 0. After release, a full 6 edges of stable input are required before `saida` rises.
